// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - FIFO read-side UART transmitter, one bit per rclk.
// Pops a word when idle or finishing a stop bit and sends start, data LSB-first, optional parity, stop.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  rinc,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q;
  logic                  par_bit;

  assign rinc = ~rrst & ~rempty & ((state == IDLE) | (state == STOP));

  // tx_out is registered alongside the state, so it always shows the bit of the current state
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      cnt      <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= (state == STOP);
      if (rinc) begin
        shift    <= rdata;
        par_en_q <= par_en;
        par_bit  <= (^rdata) ^ par_typ;
        state    <= START;
        tx_out   <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
          START: begin
            state  <= DATA;
            cnt    <= '0;
            tx_out <= shift[0];
            shift  <= shift >> 1;
          end
          DATA: begin
            if (cnt == LAST) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              tx_out <= shift[0];
              shift  <= shift >> 1;
            end
          end
          PARITY: begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
          STOP: begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
